// File: rtl/ref_read_arbiter.sv
// Round-robin arbiter that lets NUM_ENGINES requesters share one DRAM reference reader.
// A grant issues one read command and then routes the returned blocks to the owning engine.
module ref_read_arbiter #(
    parameter int NUM_ENGINES = 4,
    parameter int REF_LENGTH  = 128
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [25*NUM_ENGINES-1:0] eng_ref_addr_in,
    input  logic [25*NUM_ENGINES-1:0] eng_ref_length_in,
    input  logic [NUM_ENGINES-1:0]    eng_ref_info_valid_in,
    output logic [NUM_ENGINES-1:0]    eng_ref_info_ack_out,
    output logic [2*REF_LENGTH-1:0]   eng_ref_seq_block_out,
    output logic [NUM_ENGINES-1:0]    eng_ref_seq_block_valid_out,
    input  logic [NUM_ENGINES-1:0]    eng_ref_seq_block_rdy_in,
    output logic [24:0]               rd_addr_out,
    output logic [24:0]               rd_length_out,
    output logic                      rd_info_valid_out,
    input  logic                      rd_info_rdy_in,
    input  logic [2*REF_LENGTH-1:0]   rd_block_in,
    input  logic                      rd_block_valid_in,
    output logic                      rd_block_rdy_out,
    output logic [NUM_ENGINES-1:0]    grant_out,
    output logic                      busy_out
);
    localparam int IW = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, STREAM} state_t;

    state_t                 state_q, state_d;
    logic [IW-1:0]          ptr_q, ptr_d;
    logic [IW-1:0]          sel_q, sel_d;
    logic [24:0]            addr_q, addr_d;
    logic [24:0]            len_q, len_d;
    logic [24:0]            cnt_q, cnt_d;
    logic [NUM_ENGINES-1:0] ack_q, ack_d;

    logic [24:0]            eng_addr [NUM_ENGINES];
    logic [24:0]            eng_len  [NUM_ENGINES];
    logic                   found;
    logic [IW-1:0]          pick;
    logic                   xfer;

    generate
        for (genvar gi = 0; gi < NUM_ENGINES; gi++) begin : g_unpack
            assign eng_addr[gi] = eng_ref_addr_in[25*gi +: 25];
            assign eng_len[gi]  = eng_ref_length_in[25*gi +: 25];
            assign eng_ref_seq_block_valid_out[gi] =
                (state_q == STREAM) && (sel_q == IW'(gi)) && rd_block_valid_in;
            assign grant_out[gi] = (state_q != IDLE) && (sel_q == IW'(gi));
        end
    endgenerate

    // First requester at or after ptr_q, ascending with wrap-around.
    always_comb begin
        logic [IW:0] s;
        found = 1'b0;
        pick  = '0;
        s     = '0;
        for (int k = 0; k < NUM_ENGINES; k++) begin
            s = {1'b0, ptr_q} + (IW+1)'(k);
            if (s >= (IW+1)'(NUM_ENGINES)) begin
                s = s - (IW+1)'(NUM_ENGINES);
            end
            if (!found && eng_ref_info_valid_in[s[IW-1:0]]) begin
                found = 1'b1;
                pick  = s[IW-1:0];
            end
        end
    end

    assign xfer = (state_q == STREAM) && rd_block_valid_in && eng_ref_seq_block_rdy_in[sel_q];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        ack_d   = '0;
        case (state_q)
            IDLE: begin
                // The acked engine still shows valid during its ack cycle; skip that cycle.
                if (found && (ack_q == '0)) begin
                    sel_d       = pick;
                    addr_d      = eng_addr[pick];
                    len_d       = eng_len[pick];
                    ptr_d       = (pick == IW'(NUM_ENGINES-1)) ? '0 : pick + 1'b1;
                    ack_d[pick] = 1'b1;
                    if (eng_len[pick] != 25'd0) begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (rd_info_rdy_in) begin
                    cnt_d   = len_q;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (xfer) begin
                    cnt_d = cnt_q - 25'd1;
                    if (cnt_q == 25'd1) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
        end
    end

    assign eng_ref_info_ack_out  = ack_q;
    assign eng_ref_seq_block_out = rd_block_in;
    assign rd_addr_out           = addr_q;
    assign rd_length_out         = len_q;
    assign rd_info_valid_out     = (state_q == ISSUE);
    assign rd_block_rdy_out      = (state_q == STREAM) && eng_ref_seq_block_rdy_in[sel_q];
    assign busy_out              = (state_q != IDLE);

endmodule

// File: tb/tb_ref_read_arbiter.sv
// Scoreboard bench: a round-robin model predicts grants and block streams; a negedge monitor checks the DUT.
module tb_ref_read_arbiter;
    localparam int N  = 4;
    localparam int RL = 128;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [25*N-1:0] eng_ref_addr_in = '0;
    logic [25*N-1:0] eng_ref_length_in = '0;
    logic [N-1:0]   eng_ref_info_valid_in = '0;
    logic [N-1:0]   eng_ref_info_ack_out;
    logic [2*RL-1:0] eng_ref_seq_block_out;
    logic [N-1:0]   eng_ref_seq_block_valid_out;
    logic [N-1:0]   eng_ref_seq_block_rdy_in = '0;
    logic [24:0]    rd_addr_out;
    logic [24:0]    rd_length_out;
    logic           rd_info_valid_out;
    logic           rd_info_rdy_in = 1'b0;
    logic [2*RL-1:0] rd_block_in = '0;
    logic           rd_block_valid_in = 1'b0;
    logic           rd_block_rdy_out;
    logic [N-1:0]   grant_out;
    logic           busy_out;

    ref_read_arbiter #(.NUM_ENGINES(N), .REF_LENGTH(RL)) dut (
        .clk(clk), .rst(rst),
        .eng_ref_addr_in(eng_ref_addr_in), .eng_ref_length_in(eng_ref_length_in),
        .eng_ref_info_valid_in(eng_ref_info_valid_in), .eng_ref_info_ack_out(eng_ref_info_ack_out),
        .eng_ref_seq_block_out(eng_ref_seq_block_out),
        .eng_ref_seq_block_valid_out(eng_ref_seq_block_valid_out),
        .eng_ref_seq_block_rdy_in(eng_ref_seq_block_rdy_in),
        .rd_addr_out(rd_addr_out), .rd_length_out(rd_length_out),
        .rd_info_valid_out(rd_info_valid_out), .rd_info_rdy_in(rd_info_rdy_in),
        .rd_block_in(rd_block_in), .rd_block_valid_in(rd_block_valid_in),
        .rd_block_rdy_out(rd_block_rdy_out), .grant_out(grant_out), .busy_out(busy_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          e;
        logic [24:0] addr;
        logic [24:0] len;
    } gnt_t;

    gnt_t exp_q[$];

    // reference model / environment state (written by the sequencer only)
    int          m_ptr = 0;
    logic [24:0] b_addr [N];
    logic [24:0] b_len  [N];
    logic [N-1:0] req_mask = '0;
    logic        rd_busy = 1'b0;
    logic [24:0] rd_addr_l = '0;
    logic [24:0] rd_len_l = '0;
    int          rd_idx = 0;
    int          cmd_stall = 0;
    int          tmo = 0;
    logic        end_req = 1'b0;

    // monitor state (written by the monitor only)
    int          vectors = 0;
    int          miscompares = 0;
    gnt_t        cur;
    logic        have_cur = 1'b0;
    int          blk_cnt = 0;
    logic        rst_seen = 1'b0;
    logic        rst_prev = 1'b1;

    function automatic logic [2*RL-1:0] blk_data(input logic [24:0] a, input int i);
        logic [31:0] w;
        w = {a + 25'(i), 7'(i)};
        return {8{w}};
    endfunction

    task automatic chk(input string nm, input logic [2*RL-1:0] act, input logic [2*RL-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        gnt_t g;
        if (rst) begin
            have_cur = 1'b0;
            exp_q.delete();
            rst_seen = 1'b1;
        end else if (rst_seen) begin
            if (rst_prev) begin
                chk("post_reset_idle",
                    {busy_out, grant_out, eng_ref_info_ack_out, rd_info_valid_out,
                     rd_block_rdy_out, eng_ref_seq_block_valid_out}, '0);
            end
            if (eng_ref_info_ack_out != '0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_ack", eng_ref_info_ack_out, '0);
                end else begin
                    g = exp_q.pop_front();
                    if (have_cur) chk("block_count", blk_cnt, cur.len);
                    chk("ack_engine", eng_ref_info_ack_out, N'(1) << g.e);
                    chk("cmd_latency", rd_info_valid_out, g.len != 0);
                    $display("grant engine %0d addr %0h len %0d", g.e, g.addr, g.len);
                    cur = g;
                    have_cur = 1'b1;
                    blk_cnt = 0;
                end
            end
            if (rd_info_valid_out) begin
                chk("rd_addr", rd_addr_out, have_cur ? cur.addr : 25'h1ffffff);
                chk("rd_length", rd_length_out, have_cur ? cur.len : 25'h1ffffff);
            end
            if (busy_out && have_cur) begin
                chk("grant_onehot", grant_out, N'(1) << cur.e);
                if (!rd_info_valid_out) begin
                    chk("rd_block_rdy", rd_block_rdy_out, eng_ref_seq_block_rdy_in[cur.e]);
                    chk("block_valid_route", eng_ref_seq_block_valid_out,
                        rd_block_valid_in ? (N'(1) << cur.e) : N'(0));
                    if (rd_block_valid_in && rd_block_rdy_out) begin
                        chk("block_data", eng_ref_seq_block_out, blk_data(cur.addr, blk_cnt));
                        blk_cnt++;
                    end
                end
            end else if (!busy_out) begin
                chk("idle_outputs", {grant_out, rd_info_valid_out, rd_block_rdy_out,
                                     eng_ref_seq_block_valid_out}, '0);
            end
            if (end_req) begin
                chk("timeouts", tmo, 0);
                if (have_cur) chk("block_count", blk_cnt, cur.len);
                chk("pending_grants", exp_q.size(), 0);
                $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
                $finish;
            end
        end
        rst_prev = rst;
    end

    // ---------------- environment: reader + engines, one clock per call ----------------
    task automatic step();
        logic c_hs, b_hs, hold;
        logic [N-1:0] a;
        logic [24:0] ca, cl;
        @(negedge clk);
        c_hs = rd_info_valid_out & rd_info_rdy_in;
        b_hs = rd_block_valid_in & rd_block_rdy_out;
        a    = eng_ref_info_ack_out;
        ca   = rd_addr_out;
        cl   = rd_length_out;
        @(posedge clk);
        #1;
        hold = rd_block_valid_in && !b_hs;
        if (rst) begin
            rd_busy = 1'b0;
            rd_idx  = 0;
            hold    = 1'b0;
        end else begin
            req_mask &= ~a;
            if (b_hs) begin
                rd_idx++;
                if (rd_idx == int'(rd_len_l)) rd_busy = 1'b0;
            end
            if (c_hs) begin
                rd_busy   = 1'b1;
                rd_addr_l = ca;
                rd_len_l  = cl;
                rd_idx    = 0;
            end
        end
        // Engines with no pending request scribble their inputs; latched values must not follow.
        for (int e = 0; e < N; e++) begin
            if (!req_mask[e]) begin
                eng_ref_addr_in[25*e +: 25]   = 25'($urandom);
                eng_ref_length_in[25*e +: 25] = 25'($urandom);
            end
        end
        eng_ref_info_valid_in = req_mask;
        if (cmd_stall > 0) begin
            rd_info_rdy_in = 1'b0;
            cmd_stall--;
        end else begin
            rd_info_rdy_in = ($urandom_range(0, 2) != 0);
        end
        rd_block_valid_in = rd_busy && (hold || ($urandom_range(0, 3) != 0));
        rd_block_in = rd_busy ? blk_data(rd_addr_l, rd_idx) : {8{$urandom}};
        eng_ref_seq_block_rdy_in = N'($urandom);
    endtask

    task automatic issue(input logic [N-1:0] mask);
        int e, last;
        last = -1;
        for (int k = 0; k < N; k++) begin
            e = (m_ptr + k) % N;
            if (mask[e]) begin
                exp_q.push_back('{e, b_addr[e], b_len[e]});
                last = e;
            end
        end
        if (last >= 0) m_ptr = (last + 1) % N;
        for (int k = 0; k < N; k++) begin
            if (mask[k]) begin
                eng_ref_addr_in[25*k +: 25]   = b_addr[k];
                eng_ref_length_in[25*k +: 25] = b_len[k];
            end
        end
        req_mask |= mask;
        eng_ref_info_valid_in = req_mask;
    endtask

    task automatic wait_done();
        int cyc;
        for (cyc = 0; cyc < 3000; cyc++) begin
            step();
            if (req_mask == '0 && exp_q.size() == 0 && !rd_busy && !busy_out) break;
        end
        if (cyc >= 3000) begin
            tmo++;
            $display("FAIL batch_timeout: got busy after %0d cycles expected idle", cyc);
        end
        step();
    endtask

    initial begin
        int cyc;
        for (int k = 0; k < N; k++) begin
            b_addr[k] = '0;
            b_len[k]  = '0;
        end
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        repeat (2) step();

        // all four requesting, length 1: order 0,1,2,3 from reset
        for (int k = 0; k < N; k++) begin
            b_addr[k] = 25'(32'h40 * (k + 1));
            b_len[k]  = 25'd1;
        end
        issue(4'hF);
        wait_done();

        // single request: engine 2, addr 0x100, length 3
        b_addr[2] = 25'h100; b_len[2] = 25'd3;
        issue(4'b0100);
        wait_done();

        // zero length on engine 3 followed by engine 0
        b_addr[3] = 25'h333; b_len[3] = 25'd0;
        b_addr[0] = 25'h500; b_len[0] = 25'd2;
        issue(4'b1001);
        wait_done();

        // reader command stall for 10 cycles
        b_addr[1] = 25'h1abcd; b_len[1] = 25'd4;
        cmd_stall = 10;
        issue(4'b0010);
        wait_done();

        // reset mid-stream after two blocks, then full restart
        b_addr[0] = 25'h777; b_len[0] = 25'd5;
        issue(4'b0001);
        for (cyc = 0; cyc < 500; cyc++) begin
            if (rd_busy && rd_idx == 2) break;
            step();
        end
        if (cyc >= 500) begin
            tmo++;
            $display("FAIL reset_setup_timeout: got %0d blocks expected 2", rd_idx);
        end
        rst = 1'b1;
        m_ptr = 0;
        req_mask = '0;
        eng_ref_info_valid_in = '0;
        step();
        rst = 1'b0;
        repeat (2) step();
        issue(4'b0001);
        wait_done();

        // randomized batches
        for (int b = 0; b < 25; b++) begin
            logic [N-1:0] mask;
            mask = N'($urandom_range(1, 15));
            for (int k = 0; k < N; k++) begin
                b_addr[k] = 25'($urandom);
                b_len[k]  = 25'($urandom_range(0, 5));
            end
            if ($urandom_range(0, 3) == 0) cmd_stall = $urandom_range(1, 12);
            issue(mask);
            wait_done();
        end

        end_req = 1'b1;
        repeat (5) step();
        $display("FAIL monitor_end: got no summary expected summary");
        $fatal(1);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end
endmodule

// File: doc/ref_read_arbiter.md
REF_READ_ARBITER -- requirements
Module: ref_read_arbiter

Interface
REQ-001 Parameter NUM_ENGINES, default 4, number of Engine requesters sharing one DRAM reference reader (2..16).
REQ-002 Parameter REF_LENGTH, default 128, characters per reference block; block width is 2*REF_LENGTH bits.
REQ-003 Ports:
clk  in  1  system clock
rst  in  1  reset; one clock, synchronous, active-high
eng_ref_addr_in  in  25*NUM_ENGINES  per-engine DRAM start address; engine i at bits [25i+24:25i]
eng_ref_length_in  in  25*NUM_ENGINES  per-engine block count, same packing
eng_ref_info_valid_in  in  NUM_ENGINES  per-engine request, level, held until acked
eng_ref_info_ack_out  out  NUM_ENGINES  one-cycle grant acknowledge per engine
eng_ref_seq_block_out  out  2*REF_LENGTH  reference block, broadcast to all engines
eng_ref_seq_block_valid_out  out  NUM_ENGINES  per-engine block valid
eng_ref_seq_block_rdy_in  in  NUM_ENGINES  per-engine block ready
rd_addr_out  out  25  address to reader
rd_length_out  out  25  block count to reader
rd_info_valid_out  out  1  read command valid
rd_info_rdy_in  in  1  read command accepted
rd_block_in  in  2*REF_LENGTH  block from reader
rd_block_valid_in  in  1  block valid from reader
rd_block_rdy_out  out  1  block ready to reader
grant_out  out  NUM_ENGINES  one-hot current owner, zero when IDLE
busy_out  out  1  high in ISSUE or STREAM

Function
REQ-004 FSM states IDLE, ISSUE, STREAM; registered state.
REQ-005 IDLE: if any eng_ref_info_valid_in bit set, select index sel by round-robin search starting at pointer ptr, ascending, wrapping NUM_ENGINES-1 to 0.
REQ-006 On selection, latch addr, length and sel; pulse eng_ref_info_ack_out[sel] for exactly one cycle (the cycle after selection); set ptr = (sel+1) mod NUM_ENGINES.
REQ-007 Latched length nonzero: go to ISSUE. Latched length zero: no read command issued, ack still pulsed, remain IDLE.
REQ-008 Latency: request seen in IDLE at edge t -> rd_info_valid_out high and ack pulse in cycle t+1.
REQ-009 ISSUE: rd_info_valid_out=1, rd_addr_out/rd_length_out = latched values, held stable until rd_info_rdy_in; on valid&rdy load counter = length, go to STREAM.
REQ-010 STREAM: rd_block_rdy_out = eng_ref_seq_block_rdy_in[sel]; eng_ref_seq_block_valid_out[sel] = rd_block_valid_in; all other valid bits 0; both combinational.
REQ-011 eng_ref_seq_block_out = rd_block_in at all times (combinational passthrough).
REQ-012 Transfer = rd_block_valid_in & rd_block_rdy_out in STREAM; each decrements 25-bit counter by 1.
REQ-013 Transfer with counter==1: go to IDLE next cycle; a new grant is possible no earlier than the following IDLE cycle (one idle bubble).
REQ-014 Outside STREAM: rd_block_rdy_out=0, all eng_ref_seq_block_valid_out=0.
REQ-015 Request changes while ISSUE/STREAM are ignored; a deasserted request never aborts an active transfer.
REQ-016 Simultaneous requests: exactly one granted per IDLE decision; no engine waits more than NUM_ENGINES-1 grants.
REQ-017 grant_out = one-hot(sel) in ISSUE/STREAM, else 0; busy_out = (state != IDLE).

Reset
REQ-018 rst high at a clk edge: state=IDLE, ptr=0, counter=0, latched addr/length/sel=0; all outputs 0 except eng_ref_seq_block_out (follows rd_block_in).
REQ-019 rst mid-ISSUE or mid-STREAM aborts the transfer immediately; no ack or valid asserted in the cycle after reset.

Verification
REQ-020 Single request: engine 2, addr 0x100, length 3, reader always ready -> ack[2] one pulse, rd_info_valid 1 cycle, 3 blocks reach engine 2 only, IDLE after 3rd transfer.
REQ-021 All 4 requesting continuously, length 1 each, from reset -> grant order 0,1,2,3,0; ptr wraps correctly.
REQ-022 Backpressure: engine 1 length 4, eng rdy toggles 1,0,1,0 -> rd_block_rdy_out mirrors it, exactly 4 transfers, no block duplicated or lost.
REQ-023 Zero length: engine 3 length 0 -> ack[3] pulse, rd_info_valid_out never asserts, next requester (engine 0) granted next IDLE decision.
REQ-024 Reset mid-STREAM after 2 of 5 blocks -> next cycle busy_out=0, grant_out=0, rd_block_rdy_out=0; re-request of engine 0 restarts with full length 5.
REQ-025 Reader stall: rd_info_rdy_in low 10 cycles in ISSUE -> rd_addr_out/rd_length_out stable throughout, request changes ignored.
